// File: rtl/if_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   WORD_W           - datapath/address width
//   PC_INC           - sequential fetch stride
//   RESET_PC_DEFAULT - default first fetch address
//   fetch_state_e    - sequencer FSM encoding
package if_fetch_sequencer_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t PC_INC           = 32'd4;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/if_fetch_sequencer_if.sv
// Instruction-memory request/response bus.
//   req   - request valid (master -> slave)
//   addr  - request address (master -> slave)
//   ack   - request complete, rdata valid this cycle (slave -> master)
//   rdata - instruction word (slave -> master)
interface if_fetch_sequencer_if;
    import if_fetch_sequencer_pkg::*;

    logic  req;
    word_t addr;
    logic  ack;
    word_t rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_sequencer_pc_next_select.sv
// Next fetch address selection: redirect target or sequential PC.
//   fetch_pc - current fetch address
//   redirect - take target instead of fetch_pc + 4
//   target   - redirect destination
//   next_pc  - selected next fetch address (wraps modulo 2^32)
module pc_next_select
    import if_fetch_sequencer_pkg::*;
(
    input  word_t fetch_pc,
    input  logic  redirect,
    input  word_t target,
    output word_t next_pc
);
    assign next_pc = redirect ? target : fetch_pc + PC_INC;
endmodule

// File: rtl/if_fetch_sequencer.sv
// Instruction fetch sequencer: issues one instruction-memory request at a
// time, holds the returned instruction for IF/ID, and handles redirects
// from ID, including redirects that arrive while a request is outstanding.
//   clk, reset           - clock, synchronous active-high reset
//   stall_if             - downstream not consuming the held instruction
//   pcsrc_id             - redirect request from ID
//   branch_dest_id       - redirect target
//   imem                 - instruction-memory bus (master side)
//   instr_if, pc_if      - held instruction and its address
//   instr_valid_if       - instr_if/pc_if valid
//   pc_plus_4_if         - pc_if + 4
module if_fetch_sequencer
    import if_fetch_sequencer_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_if,
    input  logic                 pcsrc_id,
    input  word_t                branch_dest_id,
    if_fetch_sequencer_if.master imem,
    output word_t                instr_if,
    output logic                 instr_valid_if,
    output word_t                pc_if,
    output word_t                pc_plus_4_if
);
    fetch_state_e state;
    word_t        fetch_pc;
    logic         redirect_pending;
    word_t        redirect_target;
    logic         req_q;

    logic  sel_redirect;
    word_t sel_target;
    word_t next_pc;

    // A same-cycle redirect overrides one latched while the request was
    // outstanding. Outside S_FETCH the pending flag is always clear, so this
    // reduces to pcsrc_id/branch_dest_id there.
    assign sel_redirect = pcsrc_id | redirect_pending;
    assign sel_target   = pcsrc_id ? branch_dest_id : redirect_target;

    pc_next_select u_pc_next_select (
        .fetch_pc (fetch_pc),
        .redirect (sel_redirect),
        .target   (sel_target),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            fetch_pc         <= RESET_PC;
            instr_if         <= '0;
            pc_if            <= '0;
            instr_valid_if   <= 1'b0;
            redirect_pending <= 1'b0;
            redirect_target  <= '0;
            req_q            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (imem.ack) begin
                        redirect_pending <= 1'b0;
                        fetch_pc         <= next_pc;
                        if (!sel_redirect) begin
                            instr_if       <= imem.rdata;
                            pc_if          <= fetch_pc;
                            instr_valid_if <= 1'b1;
                            state          <= S_VALID;
                            req_q          <= 1'b0;
                        end
                        // Redirected: the returned word is stale; refetch
                        // from the target while staying in S_FETCH.
                    end else if (pcsrc_id) begin
                        // Address must stay stable until ack; remember the
                        // latest target and apply it when the request ends.
                        redirect_pending <= 1'b1;
                        redirect_target  <= branch_dest_id;
                    end
                end
                S_VALID: begin
                    if (pcsrc_id || !stall_if) begin
                        instr_valid_if <= 1'b0;
                        state          <= S_FETCH;
                        req_q          <= 1'b1;
                        if (pcsrc_id)
                            fetch_pc <= next_pc;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.req     = req_q;
    assign imem.addr    = fetch_pc;
    assign pc_plus_4_if = pc_if + PC_INC;
endmodule
